// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a 2-entry skid buffer.
// Decodes I/U/S/B/J/Z/SH immediates to XLEN bits and carries a sideband tag
// alongside each beat. in_ready comes straight from a flop.
// Optional feature macro: IMMGEN_ERR_EN adds an 'err' output flagging beats
// that arrived with the reserved ext_op value 7.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       ext_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef IMMGEN_ERR_EN
  output logic             err,
`endif
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state, state_next;

  logic [XLEN-1:0]  dec_imm;
  logic [XLEN-1:0]  main_imm, skid_imm;
  logic [TAG_W-1:0] main_tag, skid_tag;
  logic             in_xfer, out_xfer;
  logic [31:0]      u_word;
  logic             sgn;
  logic             unused_opcode;

  assign sgn           = instr[31];
  assign u_word        = {instr[31:12], 12'b0};
  assign unused_opcode = ^instr[6:0];

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Immediate decode; the reserved format falls back to I-type.
  always_comb begin
    dec_imm = {{(XLEN-12){sgn}}, instr[31:20]};
    case (ext_op)
      3'd1: dec_imm = XLEN'($signed(u_word));
      3'd2: dec_imm = {{(XLEN-12){sgn}}, instr[31:25], instr[11:7]};
      3'd3: dec_imm = {{(XLEN-12){sgn}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      3'd4: dec_imm = {{(XLEN-20){sgn}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      3'd5: dec_imm = XLEN'(instr[19:15]);
      3'd6: dec_imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
      default: dec_imm = {{(XLEN-12){sgn}}, instr[31:20]};
    endcase
  end

  // State register plus the registered in_ready, both cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != TWO);
    end
  end

  // Next-state: occupancy goes up on an accepted input, down on a consumed output.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (in_xfer) state_next = ONE;
      ONE: begin
        if (in_xfer && !out_xfer)      state_next = TWO;
        else if (!in_xfer && out_xfer) state_next = EMPTY;
      end
      TWO: if (out_xfer) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // Output decode: a beat is presented whenever main holds one.
  always_comb begin
    out_valid = (state != EMPTY);
    imm       = main_imm;
    out_tag   = main_tag;
  end

  // Datapath: main feeds the output, skid catches the beat that arrives while main is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_imm <= '0;
      main_tag <= '0;
      skid_imm <= '0;
      skid_tag <= '0;
    end else begin
      case (state)
        EMPTY: if (in_xfer) begin
          main_imm <= dec_imm;
          main_tag <= in_tag;
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_imm <= dec_imm;
            main_tag <= in_tag;
          end else if (in_xfer) begin
            skid_imm <= dec_imm;
            skid_tag <= in_tag;
          end
        end
        TWO: if (out_xfer) begin
          main_imm <= skid_imm;
          main_tag <= skid_tag;
        end
        default: ;
      endcase
    end
  end

`ifdef IMMGEN_ERR_EN
  logic main_err, skid_err, dec_err;

  assign dec_err = (ext_op == 3'd7);
  assign err     = main_err;

  // Error flag follows its beat through main and skid exactly like the tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_err <= 1'b0;
      skid_err <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (in_xfer) main_err <= dec_err;
        ONE: begin
          if (in_xfer && out_xfer) main_err <= dec_err;
          else if (in_xfer)        skid_err <= dec_err;
        end
        TWO: if (out_xfer) main_err <= skid_err;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: a queue-based reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_imm_gen_pipe;
  localparam int XLEN  = 32;
  localparam int TAG_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [2:0]       ext_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm;
  logic [TAG_W-1:0] out_tag;
  logic             err;

`ifndef IMMGEN_ERR_EN
  assign err = 1'b0;
`endif

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .instr(instr),
    .ext_op(ext_op),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef IMMGEN_ERR_EN
    .err(err),
`endif
    .imm(imm),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
    int               cyc;
  } beat_t;

  beat_t model_q[$];
  beat_t seen_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cycle    = 0;
  bit    checking = 0;

  // Immediate value from the format rules, using plain arithmetic on the word.
  function automatic logic [63:0] model_imm(input logic [31:0] i, input logic [2:0] op);
    longint s;
    longint v;
    s = longint'($signed(i));
    case (op)
      3'd1: v = s & ~longint'(4095);
      3'd2: v = ((s >>> 20) & ~longint'(31)) | longint'((i >> 7) & 31);
      3'd3: v = ((s >>> 31) << 12) | longint'(((i >> 7) & 1) << 11)
              | longint'(((i >> 25) & 63) << 5) | longint'(((i >> 8) & 15) << 1);
      3'd4: v = ((s >>> 31) << 20) | longint'(((i >> 12) & 255) << 12)
              | longint'(((i >> 20) & 1) << 11) | longint'(((i >> 21) & 1023) << 1);
      3'd5: v = longint'((i >> 15) & 31);
      3'd6: v = longint'((i >> 20) & ((XLEN == 32) ? 31 : 63));
      default: v = s >>> 20;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Model update: occupancy and order of beats, decided from pre-edge contents.
  always @(posedge clk) begin
    bit          ox;
    bit          ix;
    beat_t       b;
    logic [63:0] full;
    cycle++;
    if (rst) begin
      model_q.delete();
    end else begin
      ox = (model_q.size() > 0) && (out_ready === 1'b1);
      ix = (in_valid === 1'b1) && (model_q.size() < 2);
      if (ox) void'(model_q.pop_front());
      if (ix) begin
        full  = model_imm(instr, ext_op);
        b.imm = full[XLEN-1:0];
        b.tag = in_tag;
`ifdef IMMGEN_ERR_EN
        b.err = (ext_op == 3'd7);
`else
        b.err = 1'b0;
`endif
        b.cyc = 0;
        model_q.push_back(b);
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    beat_t b;
    if (checking) begin
      checkOutput("out_valid", {63'b0, out_valid}, {63'b0, model_q.size() > 0});
      checkOutput("in_ready", {63'b0, in_ready}, {63'b0, model_q.size() < 2});
      if (model_q.size() > 0) begin
        checkOutput("imm", 64'(imm), 64'(model_q[0].imm));
        checkOutput("out_tag", 64'(out_tag), 64'(model_q[0].tag));
        checkOutput("err", {63'b0, err}, {63'b0, model_q[0].err});
        if (out_ready === 1'b1 && out_valid === 1'b1) begin
          b.imm = imm;
          b.tag = out_tag;
          b.err = err;
          b.cyc = cycle;
          seen_q.push_back(b);
        end
      end
    end
  end

  // Present one beat and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [31:0] i, input logic [2:0] op,
                               input logic [TAG_W-1:0] t, output int waits);
    bit acc;
    acc      = 0;
    waits    = 0;
    in_valid = 1'b1;
    instr    = i;
    ext_op   = op;
    in_tag   = t;
    while (!acc && waits < 100) begin
      acc = (in_ready === 1'b1);
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    in_valid = 1'b0;
    if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && model_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("drain", 64'(model_q.size()), 64'd0);
  endtask

  logic [31:0] sw_instr [5] = '{32'h123450B7, 32'hFE000EE3, 32'h0080006F, 32'h000FD073, 32'h41F0D093};
  logic [2:0]  sw_op    [5] = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd6};
  logic [63:0] sw_exp   [5] = '{64'h0000_0000_1234_5000, 64'hFFFF_FFFF_FFFF_FFFC,
                                64'h0000_0000_0000_0008, 64'h0000_0000_0000_001F,
                                64'h0000_0000_0000_001F};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          w;
    int          total;
    logic [63:0] e;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = '0;
    ext_op    = '0;
    in_tag    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("reset_in_ready", {63'b0, in_ready}, 64'd1);
    checkOutput("reset_imm", 64'(imm), 64'd0);
    checkOutput("reset_tag", 64'(out_tag), 64'd0);
    rst      = 1'b0;
    checking = 1;

    $display("[TB] single beat");
    out_ready = 1'b1;
    applyStimulus(32'hFFF00093, 3'd0, 'h100, w);
    e = 64'hFFFF_FFFF_FFFF_FFFF;
    checkOutput("single_valid", {63'b0, out_valid}, 64'd1);
    checkOutput("single_imm", 64'(imm), 64'(e[XLEN-1:0]));
    checkOutput("single_tag", 64'(out_tag), 64'h100);
    drain();

    $display("[TB] format sweep");
    seen_q.delete();
    for (int k = 0; k < 5; k++) applyStimulus(sw_instr[k], sw_op[k], TAG_W'(32'h200 + k), w);
    drain();
    checkOutput("sweep_count", 64'(seen_q.size()), 64'd5);
    for (int k = 0; k < 5 && k < seen_q.size(); k++) begin
      e = sw_exp[k];
      checkOutput($sformatf("sweep_imm%0d", k), 64'(seen_q[k].imm), 64'(e[XLEN-1:0]));
      checkOutput($sformatf("sweep_tag%0d", k), 64'(seen_q[k].tag), 64'(32'h200 + k));
      if (k > 0) checkOutput($sformatf("sweep_rate%0d", k), 64'(seen_q[k].cyc - seen_q[k-1].cyc), 64'd1);
    end

    $display("[TB] backpressure");
    seen_q.delete();
    out_ready = 1'b0;
    fork
      begin
        for (int t = 1; t <= 4; t++) applyStimulus(32'h00000093 | (t << 20), 3'd0, TAG_W'(t), w);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        checkOutput("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
        checkOutput("bp_hold_tag", 64'(out_tag), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_hold_tag_later", 64'(out_tag), 64'd1);
        checkOutput("bp_hold_imm", 64'(imm), 64'd1);
        out_ready = 1'b1;
      end
    join
    drain();
    checkOutput("bp_count", 64'(seen_q.size()), 64'd4);
    for (int k = 0; k < 4 && k < seen_q.size(); k++)
      checkOutput($sformatf("bp_order%0d", k), 64'(seen_q[k].tag), 64'(k + 1));

    $display("[TB] simultaneous transfer");
    seen_q.delete();
    out_ready = 1'b1;
    total     = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(32'h00000013 | (k << 20), 3'(k % 7), TAG_W'(32'h400 + k), w);
      total += w;
    end
    checkOutput("simul_no_stall", 64'(total), 64'd0);
    drain();
    checkOutput("simul_count", 64'(seen_q.size()), 64'd8);

    $display("[TB] reset mid-operation");
    out_ready = 1'b0;
    applyStimulus(32'h00100093, 3'd0, 'h501, w);
    applyStimulus(32'h00200093, 3'd0, 'h502, w);
    checkOutput("pre_reset_two", {63'b0, in_ready}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("rst_in_ready", {63'b0, in_ready}, 64'd1);
    checkOutput("rst_imm", 64'(imm), 64'd0);
    checkOutput("rst_tag", 64'(out_tag), 64'd0);
    seen_q.delete();
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rst_discard", 64'(seen_q.size()), 64'd0);

`ifdef IMMGEN_ERR_EN
    $display("[TB] reserved format error flag");
    seen_q.delete();
    applyStimulus(32'h00500093, 3'd7, 'h600, w);
    applyStimulus(32'h00500093, 3'd0, 'h601, w);
    drain();
    checkOutput("err_count", 64'(seen_q.size()), 64'd2);
    if (seen_q.size() >= 2) begin
      checkOutput("err_imm", 64'(seen_q[0].imm), 64'd5);
      checkOutput("err_set", {63'b0, seen_q[0].err}, 64'd1);
      checkOutput("err_clear", {63'b0, seen_q[1].err}, 64'd0);
    end
`endif

    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
